// File: rtl/halflife_pkg.sv
// halflife_pkg: shared FSM state type, default widths and saturation constant for the half-life meter
package halflife_pkg;
    localparam int DW_DEF  = 8;
    localparam int CW_DEF  = 11;
    localparam int CNT_MAX = 2**CW_DEF - 1;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
endpackage

// File: rtl/halflife_sat_cnt.sv
// halflife_sat_cnt: CW-bit up counter that saturates at all-ones
// ports: clk, rst (async, active-high), clr (sync clear), en (count), q (value), at_max (q is all-ones)
module halflife_sat_cnt #(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q,
    output logic          at_max
);
    assign at_max = &q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else q <= clr ? '0 : (en && !at_max) ? q + 1'b1 : q;
endmodule

// File: rtl/halflife_meter.sv
// halflife_meter: counts valid samples until a decaying sample falls to half its reference value
// ports: clk, rst (async, active-high); start/abort control; sample_valid/sample input stream;
//        busy (ARM or MEASURE), done (one-cycle result pulse), halflife/ref_val/timeout/zero_ref results
module halflife_meter
    import halflife_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] halflife,
    output logic [DW-1:0] ref_val,
    output logic          timeout,
    output logic          zero_ref
);
    state_t        state, state_n;
    logic [DW-1:0] thr;
    logic [CW-1:0] cnt, hl_n;
    logic          clr, cap, fin, to_n, zr_n, at_max;

    halflife_sat_cnt #(.CW(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (state == MEASURE && sample_valid && !abort),
        .q      (cnt),
        .at_max (at_max)
    );

    assign busy = (state == ARM) || (state == MEASURE);

    // abort is tested first in ARM/MEASURE so it wins over capture and completion
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        cap     = 1'b0;
        fin     = 1'b0;
        hl_n    = '0;
        to_n    = 1'b0;
        zr_n    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = ARM;
                    clr     = 1'b1;
                end
            end
            ARM: begin
                if (abort) state_n = IDLE;
                else if (sample_valid) begin
                    cap = 1'b1;
                    if (sample == '0) begin
                        state_n = DONE;
                        fin     = 1'b1;
                        zr_n    = 1'b1;
                    end else state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (abort) state_n = IDLE;
                // counter already holds 2^CW-1 valid samples without halving
                else if (at_max) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    hl_n    = cnt;
                    to_n    = 1'b1;
                end else if (sample_valid && sample <= thr) begin
                    state_n = DONE;
                    fin     = 1'b1;
                    hl_n    = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            thr      <= '0;
            ref_val  <= '0;
            halflife <= '0;
            timeout  <= 1'b0;
            zero_ref <= 1'b0;
        end else begin
            state <= state_n;
            done  <= fin;
            if (cap) begin
                ref_val <= sample;
                thr     <= sample >> 1;
            end
            if (fin) begin
                halflife <= hl_n;
                timeout  <= to_n;
                zero_ref <= zr_n;
            end
        end
endmodule

// File: doc/halflife_meter.md
HALFLIFE_METER -- requirements
Module: halflife_meter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 8, sample width.
- CW, 11, interval counter width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- start, in, 1, arm a measurement (sampled in IDLE/DONE only).
- abort, in, 1, cancel a measurement in progress.
- sample_valid, in, 1, sample qualifier.
- sample, in, DW, decaying quantity from the timer under test.
- busy, out, 1, high in ARM or MEASURE.
- done, out, 1, one-cycle pulse on result update.
- halflife, out, CW, measured interval in valid samples; held until the next done.
- ref_val, out, DW, captured reference sample.
- timeout, out, 1, result flag: no halving within 2^CW-1 samples.
- zero_ref, out, 1, result flag: reference sample was 0.

Function
REQ-003 FSM states SHALL be IDLE, ARM, MEASURE, DONE.
REQ-004 IDLE or DONE with start=1 SHALL go to ARM on the next edge and clear the interval counter.
REQ-005 In ARM, the first cycle with sample_valid=1 SHALL load ref_val=sample and threshold=sample>>1 (floor), then go to MEASURE.
REQ-006 If the captured reference is 0, the block SHALL instead go to DONE with halflife=0, zero_ref=1, timeout=0, and done pulsed.
REQ-007 In MEASURE, each cycle with sample_valid=1 SHALL increment the counter by 1; cycles with sample_valid=0 SHALL hold it.
REQ-008 A valid sample <= threshold SHALL go to DONE, with halflife = count including that sample, done=1 for that one cycle, and timeout=0, zero_ref=0.
REQ-009 If the counter reaches 2^CW-1 without meeting the condition in REQ-008, the block SHALL go to DONE with halflife=2^CW-1 and timeout=1; the counter SHALL never wrap.
REQ-010 Samples rising above ref_val SHALL NOT restart or alter the measurement.
REQ-011 abort=1 in ARM or MEASURE SHALL return to IDLE with no done pulse and SHALL leave the previous result unchanged.
REQ-012 abort SHALL take priority over start and over a completion occurring in the same cycle.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 done SHALL be registered and asserted exactly one cycle per completion.
REQ-015 busy SHALL deassert in the same cycle done asserts.
REQ-016 DONE SHALL behave as IDLE for start, and the result outputs SHALL remain stable there.

Reset
REQ-017 rst=1 SHALL asynchronously force state=IDLE, counter=0, threshold=0, ref_val=0, halflife=0, and busy, done, timeout, zero_ref all 0.
REQ-018 Reset asserted mid-measurement SHALL discard the measurement with no done pulse.
REQ-019 After rst deasserts, the first start SHALL be honored on the first edge.

Structure
REQ-020 Package halflife_pkg SHALL hold the FSM state enum, the DW/CW defaults, and the saturation constant CNT_MAX.
REQ-021 Sub-module halflife_sat_cnt SHALL provide the CW-bit saturating counter with clear, enable, and an at_max flag.
REQ-022 All remaining logic SHALL stay in halflife_meter.
REQ-023 The counter's reset SHALL use the same asynchronous rst as halflife_meter.

Verification
REQ-024 Ideal halving: start, then valid samples 200,180,150,120,100 -> ref_val=200, halflife=4, done one cycle, timeout=0.
REQ-025 Gaps: reference 64, then valid 40,33,32 with sample_valid=0 cycles interleaved -> halflife=3.
REQ-026 Odd reference and zero: reference 7 (threshold 3) then 5,3 -> halflife=2; reference 0 -> zero_ref=1, halflife=0, done after capture.
REQ-027 Saturation at CW=4: reference 100, then 20 valid samples of 90 -> halflife=15, timeout=1, counter not wrapped.
REQ-028 Abort and reset: abort asserted with a completing sample in the same cycle -> IDLE, no done, previous halflife kept; rst mid-MEASURE -> all outputs 0, no done.
REQ-029 Start-while-busy: start pulsed during MEASURE -> ignored, and the result matches the uninterrupted run.
